alu_seq_ctrl: RTL and testbench

- Sequencer that owns the shared 6-bit ALU datapath in the switch/LED lab top level.
- Operand and function registers are loaded from sw[7:6] (command) and sw[5:0] (data), one load per en rising edge.
- A "run" command iterates y(n+2) = y(n) op y(n+1) for N steps on the external ALU, then returns to idle with the result on led.

---
 rtl/alu_seq_ctrl_pkg.sv | 19 +
 rtl/alu_seq_ctrl_edge_pulse.sv | 22 ++
 rtl/alu_seq_ctrl.sv | 114 +++++++++++
 tb/tb_alu_seq_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types for the ALU sequencer: command codes,
// controller states and the ALU add function code.
package alu_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_LDA = 2'd0,
    CMD_LDB = 2'd1,
    CMD_LDF = 2'd2,
    CMD_RUN = 2'd3
  } cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [2:0] FN_ADD = 3'b000;

endpackage

// File: rtl/alu_seq_ctrl_edge_pulse.sv
// Rising-edge detector: one-cycle pulse per low-to-high
// transition of a synchronous level. Ports: clk, rstn, level, pulse.
module alu_seq_ctrl_edge_pulse (
  input  logic clk,
  input  logic rstn,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer owning the external ALU: loads A/B/F from sw on en edges,
// runs y(n+2)=y(n) op y(n+1) for N steps. Ports: clk, rstn, sw, en,
// alu_a/b/f out, alu_y in, busy, led={busy,done,B}.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int FW    = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       sw,
  input  logic             en,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FW-1:0]    alu_f,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy,
  output logic [7:0]       led
);

  state_e           state, state_n;
  logic [WIDTH-1:0] a, a_n;
  logic [WIDTH-1:0] b, b_n;
  logic [FW-1:0]    f, f_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic             done, done_n;
  logic             cmd_pulse;
  cmd_e             sel;
  logic [WIDTH-1:0] data;

  assign sel  = cmd_e'(sw[7:6]);
  assign data = sw[WIDTH-1:0];

  alu_seq_ctrl_edge_pulse u_edge (
    .clk   (clk),
    .rstn  (rstn),
    .level (en),
    .pulse (cmd_pulse)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      f     <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      f     <= f_n;
      cnt   <= cnt_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    f_n     = f;
    cnt_n   = cnt;
    done_n  = done;
    unique case (state)
      IDLE: begin
        if (cmd_pulse) begin
          unique case (sel)
            CMD_LDA: begin
              a_n    = data;
              done_n = 1'b0;
            end
            CMD_LDB: begin
              b_n    = data;
              done_n = 1'b0;
            end
            CMD_LDF: begin
              f_n    = data[FW-1:0];
              done_n = 1'b0;
            end
            CMD_RUN: begin
              // A zero-length run finishes on the spot.
              if (data != '0) begin
                cnt_n   = data;
                done_n  = 1'b0;
                state_n = RUN;
              end else begin
                done_n  = 1'b1;
              end
            end
          endcase
        end
      end
      RUN: begin
        a_n   = b;
        b_n   = alu_y;
        cnt_n = cnt - 1'b1;
        if (cnt == WIDTH'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    endcase
  end

  assign alu_a = a;
  assign alu_b = b;
  assign alu_f = f;
  assign busy  = (state == RUN);
  assign led   = {busy, done, b};

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a small external ALU and a
// sequence-level reference model checked every cycle.
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rstn;
  logic [7:0] sw;
  logic       en;
  logic [5:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_f;
  logic       busy;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl #(.WIDTH(6), .FW(3)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .sw    (sw),
    .en    (en),
    .alu_a (alu_a),
    .alu_b (alu_b),
    .alu_f (alu_f),
    .alu_y (alu_y),
    .busy  (busy),
    .led   (led)
  );

  function automatic logic [5:0] alu_fn(
    input logic [5:0] x, input logic [5:0] y, input logic [2:0] fn);
    case (fn)
      3'd0:    return x + y;
      3'd1:    return x - y;
      3'd2:    return x & y;
      3'd3:    return x | y;
      3'd4:    return x ^ y;
      3'd5:    return x;
      3'd6:    return y;
      default: return ~x;
    endcase
  endfunction

  assign alu_y = alu_fn(alu_a, alu_b, alu_f);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a run is expanded up front into the list of
  // (A,B) pairs it must produce, one per RUN cycle.
  logic [5:0]  m_a, m_b;
  logic [2:0]  m_f;
  logic        m_done, m_enq;
  logic [11:0] rq[$];

  initial begin
    logic       pulse;
    logic [5:0] x, y, z, d;
    m_a = 0; m_b = 0; m_f = 0; m_done = 0; m_enq = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_a = 0; m_b = 0; m_f = 0; m_done = 0; m_enq = 0;
        rq.delete();
      end else begin
        pulse = en && !m_enq;
        m_enq = en;
        d = sw[5:0];
        if (rq.size() > 0) begin
          {m_a, m_b} = rq.pop_front();
          if (rq.size() == 0) m_done = 1;
        end else if (pulse) begin
          case (sw[7:6])
            2'd0: begin m_a = d; m_done = 0; end
            2'd1: begin m_b = d; m_done = 0; end
            2'd2: begin m_f = d[2:0]; m_done = 0; end
            default: begin
              if (d == 0) m_done = 1;
              else begin
                m_done = 0;
                x = m_a; y = m_b;
                for (int i = 0; i < int'(d); i++) begin
                  z = alu_fn(x, y, m_f);
                  x = y; y = z;
                  rq.push_back({x, y});
                end
              end
            end
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      check("alu_a", 16'(alu_a), 16'(m_a));
      check("alu_b", 16'(alu_b), 16'(m_b));
      check("alu_f", 16'(alu_f), 16'(m_f));
      check("busy", 16'(busy), 16'(rq.size() != 0));
      check("led", 16'(led),
            16'({rq.size() != 0, m_done, m_b}));
    end
  end

  task automatic cmd(input logic [1:0] s, input logic [5:0] d);
    @(negedge clk);
    sw = {s, d};
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic run_wait(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic [1:0] s;
    logic [5:0] d;
    rstn = 1'b0;
    sw = 8'h00;
    en = 1'b0;
    #22 rstn = 1'b1;
    #1;
    check("rst_led", 16'(led), 16'h00);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_f", 16'(alu_f), 16'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sw = 8'($urandom);
    end
    @(negedge clk);
    check("noen_a", 16'(alu_a), 16'h0);

    cmd(2'd0, 6'd1);
    cmd(2'd1, 6'd1);
    cmd(2'd2, 6'd0);
    cmd(2'd3, 6'd5);
    run_wait(n);
    check("fib_len", 16'(n), 16'd5);
    check("fib_led", 16'(led), 16'h4D);

    cmd(2'd0, 6'd21);
    cmd(2'd1, 6'd34);
    cmd(2'd3, 6'd3);
    run_wait(n);
    check("wrap_len", 16'(n), 16'd3);
    check("wrap_led", 16'(led), 16'h50);

    @(negedge clk);
    sw = {2'd0, 6'd7};
    en = 1'b1;
    @(negedge clk);
    sw = {2'd0, 6'd12};
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("held_a", 16'(alu_a), 16'd7);

    cmd(2'd3, 6'd10);
    repeat (3) @(negedge clk);
    sw = {2'd0, 6'd9};
    en = 1'b1;
    run_wait(n);
    check("ign_len", 16'(n), 16'd7);
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("ign_a", 16'(alu_a), 16'd30);
    check("ign_b", 16'(alu_b), 16'd17);

    cmd(2'd3, 6'd0);
    check("n0_led", 16'(led), 16'h51);
    cmd(2'd1, 6'd5);
    check("clr_led", 16'(led), 16'h05);

    for (int i = 0; i < 60; i++) begin
      s = 2'($urandom_range(0, 3));
      d = 6'($urandom);
      if (s == 2'd3) d = d % 6'd13;
      cmd(s, d);
      if (s == 2'd3) begin
        run_wait(n);
        check("rnd_len", 16'(n), 16'(d));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    cmd(2'd3, 6'd20);
    repeat (3) @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    check("mid_a", 16'(alu_a), 16'h0);
    check("mid_b", 16'(alu_b), 16'h0);
    check("mid_f", 16'(alu_f), 16'h0);
    check("mid_busy", 16'(busy), 16'h0);
    check("mid_led", 16'(led), 16'h00);
    #10 rstn = 1'b1;
    cmd(2'd0, 6'd33);
    check("post_a", 16'(alu_a), 16'd33);
    check("post_led", 16'(led), 16'h00);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
